// File: rtl/sm_peak_track_if.sv
// sm_peak_track_if: bundles the sample input handshake, the comparator
// operand/result path and the peak result handshake of sm_peak_track.
//   WIDTH : sample width (sign bit + WIDTH-1 magnitude bits)
//   CNT_W : width of the peak index ($clog2 of the window length)
// Modports:
//   slave  : the peak tracker itself
//   master : the environment (sample source, comparator, result consumer)
// Signals:
//   InValid/InReady/InData       sample stream in
//   CmpA/CmpB/CmpAGEB            comparator operands out, A >= B result in
//   PeakValid/PeakReady          result handshake
//   PeakData/PeakIdx             peak sample and its 0-based window position
interface sm_peak_track_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
);

  logic             InValid;
  logic             InReady;
  logic [WIDTH-1:0] InData;

  logic [WIDTH-1:0] CmpA;
  logic [WIDTH-1:0] CmpB;
  logic             CmpAGEB;

  logic             PeakValid;
  logic             PeakReady;
  logic [WIDTH-1:0] PeakData;
  logic [CNT_W-1:0] PeakIdx;

  modport slave (
    input  InValid,
    output InReady,
    input  InData,
    output CmpA,
    output CmpB,
    input  CmpAGEB,
    output PeakValid,
    input  PeakReady,
    output PeakData,
    output PeakIdx
  );

  modport master (
    output InValid,
    input  InReady,
    output InData,
    input  CmpA,
    input  CmpB,
    output CmpAGEB,
    input  PeakValid,
    output PeakReady,
    input  PeakData,
    input  PeakIdx
  );

endinterface

// File: rtl/sm_peak_track.sv
// sm_peak_track: windowed peak tracker for sign-magnitude samples.
// Over each window of WINDOW accepted samples it keeps the running extreme
// and its 0-based index, using an external combinational sign-magnitude
// A >= B comparator, then offers the result on a valid/ready handshake.
// Ports:
//   Clock : rising-edge clock
//   Reset : asynchronous, active-high reset
//   bus   : sm_peak_track_if.slave (sample in, comparator, peak out)
// Parameters:
//   WIDTH  : sample width, fixed at 8 by the comparator stage
//   WINDOW : samples per window, legal range 2..256
// Build option:
//   SM_PEAK_MIN_EN : when defined, track the minimum instead of the maximum
//                    (operands swapped; later sample still wins ties).
module sm_peak_track #(
  parameter  int unsigned WIDTH  = 8,
  parameter  int unsigned WINDOW = 16,
  localparam int unsigned CNT_W  = $clog2(WINDOW)
) (
  input  logic            Clock,
  input  logic            Reset,
  sm_peak_track_if.slave  bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACC  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WINDOW - 1);

  logic [1:0]       state_q,      state_d;
  logic [WIDTH-1:0] peak_q,       peak_d;
  logic [CNT_W-1:0] idx_q,        idx_d;
  logic [CNT_W-1:0] cnt_q,        cnt_d;
  logic             in_ready_q,   in_ready_d;
  logic             peak_valid_q, peak_valid_d;

  logic             accept_c;

  // in_ready_q is a registered copy of (state != HOLD)
  assign accept_c = bus.InValid & in_ready_q;

  // Comparator operands: the "A >= B" sense selects max or min tracking
`ifdef SM_PEAK_MIN_EN
  assign bus.CmpA = peak_q;
  assign bus.CmpB = bus.InData;
`else
  assign bus.CmpA = bus.InData;
  assign bus.CmpB = peak_q;
`endif

  assign bus.InReady   = in_ready_q;
  assign bus.PeakValid = peak_valid_q;
  assign bus.PeakData  = peak_q;
  assign bus.PeakIdx   = idx_q;

  // State and datapath registers
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q      <= IDLE;
      peak_q       <= '0;
      idx_q        <= '0;
      cnt_q        <= '0;
      in_ready_q   <= 1'b1;
      peak_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      peak_q       <= peak_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      in_ready_q   <= in_ready_d;
      peak_valid_q <= peak_valid_d;
    end
  end

  // Next-state, datapath update and registered handshake flags
  always_comb begin
    state_d = state_q;
    peak_d  = peak_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE: begin
        // First sample of a window is the peak by definition
        if (accept_c) begin
          peak_d  = bus.InData;
          idx_d   = '0;
          cnt_d   = CNT_W'(1);
          state_d = ACC;
        end
      end

      ACC: begin
        if (accept_c) begin
          // >= lets the later sample win ties, including -0 vs +0
          if (bus.CmpAGEB) begin
            peak_d = bus.InData;
            idx_d  = cnt_q;
          end
          if (cnt_q == LAST_CNT) begin
            cnt_d   = '0;
            state_d = HOLD;
          end else begin
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end
      end

      HOLD: begin
        // Result held until consumed; input is stalled via InReady
        if (bus.PeakReady) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    in_ready_d   = (state_d != HOLD);
    peak_valid_d = (state_d == HOLD);
  end

endmodule
